// File: rtl/starfield_ramp.sv
// Starfield register-write master: ramps H/V star velocity toward CPU targets once
// per FRAMES vblanks and pushes the changed registers during vblank start.
module starfield_ramp #(
  parameter logic [15:0] STEP   = 16'd32,
  parameter logic [7:0]  FRAMES = 8'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_vblank,
  input  logic        i_en_req,
  input  logic [15:0] i_tgt_h,
  input  logic [15:0] i_tgt_v,
  input  logic        i_snap,
  output logic [2:0]  o_sf_addr,
  output logic [7:0]  o_sf_data,
  output logic        o_sf_write,
  output logic        o_busy,
  output logic        o_at_target,
  output logic        o_overrun
);

  localparam int unsigned NWR     = 5;
  localparam logic [7:0]  FR_LAST = (FRAMES == 8'd0) ? 8'd0 : FRAMES - 8'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_W_EN, S_W_H1, S_W_H2, S_W_V3, S_W_V4
  } state_t;

  state_t             r_state, w_next;
  logic [NWR-1:0]     r_pend, w_pend;
  logic               r_vblank_q, r_edge, r_tick, r_snap;
  logic               r_en_last, r_dirty_en, r_dirty_h, r_dirty_v;
  logic [7:0]         r_cnt;
  logic signed [15:0] r_cur_h, r_cur_v;
  logic [2:0]         r_addr, w_addr;
  logic [7:0]         r_data, w_data;
  logic               r_write, w_write, r_busy, r_at_target, r_overrun;

  logic               w_tick, w_en_dirty, w_dh, w_dv;
  logic signed [15:0] w_new_h, w_new_v, w_cur_h, w_cur_v;
  logic [14:0]        w_mag_h, w_mag_v;

  // -32768 has no positive counterpart in sign/magnitude form
  function automatic logic signed [15:0] clamp_tgt(input logic [15:0] x);
    return (x == 16'h8000) ? 16'sh8001 : $signed(x);
  endfunction

  function automatic logic signed [15:0] ramp_axis(input logic signed [15:0] cur,
                                                   input logic signed [15:0] tgt,
                                                   input logic snap);
    logic signed [16:0] d, ad, st;
    d  = 17'(tgt) - 17'(cur);
    ad = d[16] ? -d : d;
    st = $signed({1'b0, STEP});
    if (snap || (ad <= st)) return tgt;
    else if (!d[16])        return 16'(17'(cur) + st);
    else                    return 16'(17'(cur) - st);
  endfunction

  function automatic logic [14:0] mag15(input logic signed [15:0] v);
    return v[15] ? (15'd0 - v[14:0]) : v[14:0];
  endfunction

  function automatic state_t first_wr(input logic [NWR-1:0] m);
    if (m[0])      return S_W_EN;
    else if (m[1]) return S_W_H1;
    else if (m[2]) return S_W_H2;
    else if (m[3]) return S_W_V3;
    else if (m[4]) return S_W_V4;
    else           return S_IDLE;
  endfunction

  // Ramp math; only committed in CALC on a ramp tick
  always_comb begin
    w_tick     = (r_cnt == FR_LAST);
    w_en_dirty = r_dirty_en | (i_en_req != r_en_last);
    w_new_h    = ramp_axis(r_cur_h, clamp_tgt(i_tgt_h), r_snap);
    w_new_v    = ramp_axis(r_cur_v, clamp_tgt(i_tgt_v), r_snap);
    w_cur_h    = (r_state == S_CALC && r_tick) ? w_new_h : r_cur_h;
    w_cur_v    = (r_state == S_CALC && r_tick) ? w_new_v : r_cur_v;
    w_dh       = r_dirty_h | (w_cur_h != r_cur_h);
    w_dv       = r_dirty_v | (w_cur_v != r_cur_v);
    w_mag_h    = mag15(w_cur_h);
    w_mag_v    = mag15(w_cur_v);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_pend;
    end
  end

  // Next state: jump straight to the next pending write, no bubbles
  always_comb begin
    w_next = r_state;
    w_pend = r_pend;
    unique case (r_state)
      S_IDLE: if (r_edge && (w_tick || w_en_dirty)) w_next = S_CALC;
      S_CALC: begin
        w_pend = {w_dv & r_tick, w_dv & r_tick, w_dh & r_tick, w_dh & r_tick, w_en_dirty};
        w_next = first_wr(w_pend);
      end
      S_W_EN: begin w_pend = r_pend & 5'b11110; w_next = first_wr(w_pend); end
      S_W_H1: begin w_pend = r_pend & 5'b11100; w_next = first_wr(w_pend); end
      S_W_H2: begin w_pend = r_pend & 5'b11000; w_next = first_wr(w_pend); end
      S_W_V3: begin w_pend = r_pend & 5'b10000; w_next = first_wr(w_pend); end
      S_W_V4: begin w_pend = '0;                w_next = S_IDLE;            end
      default: begin w_pend = '0;               w_next = S_IDLE;            end
    endcase
  end

  // Output values for the state being entered
  always_comb begin
    w_addr  = r_addr;
    w_data  = r_data;
    w_write = 1'b0;
    case (w_next)
      S_W_EN: begin w_write = 1'b1; w_addr = 3'd0; w_data = {7'b0, i_en_req};              end
      S_W_H1: begin w_write = 1'b1; w_addr = 3'd1; w_data = {~w_cur_h[15], w_mag_h[14:8]}; end
      S_W_H2: begin w_write = 1'b1; w_addr = 3'd2; w_data = w_mag_h[7:0];                  end
      S_W_V3: begin w_write = 1'b1; w_addr = 3'd3; w_data = {~w_cur_v[15], w_mag_v[14:8]}; end
      S_W_V4: begin w_write = 1'b1; w_addr = 3'd4; w_data = w_mag_v[7:0];                  end
      default: ;
    endcase
  end

  // Edge detect, frame counter, velocity and dirty tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblank_q <= 1'b0;
      r_edge     <= 1'b0;
      r_cnt      <= 8'd0;
      r_tick     <= 1'b0;
      r_snap     <= 1'b0;
      r_en_last  <= 1'b0;
      r_dirty_en <= 1'b1;
      r_dirty_h  <= 1'b1;
      r_dirty_v  <= 1'b1;
      r_cur_h    <= 16'sd0;
      r_cur_v    <= 16'sd0;
    end else begin
      r_vblank_q <= i_vblank;
      r_edge     <= i_vblank & ~r_vblank_q;
      if (r_state == S_IDLE && r_edge) begin
        r_cnt  <= w_tick ? 8'd0 : r_cnt + 8'd1;
        r_tick <= w_tick;
      end
      r_snap <= i_snap | (r_snap & ~(r_state == S_CALC && r_tick));
      if (r_state == S_CALC) begin
        r_cur_h   <= w_cur_h;
        r_cur_v   <= w_cur_v;
        r_dirty_h <= w_dh;
        r_dirty_v <= w_dv;
      end
      if (w_next == S_W_EN) begin
        r_dirty_en <= 1'b0;
        r_en_last  <= i_en_req;
      end
      if (w_next == S_W_H2) r_dirty_h <= 1'b0;
      if (w_next == S_W_V4) r_dirty_v <= 1'b0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= 3'd0;
      r_data      <= 8'd0;
      r_write     <= 1'b0;
      r_busy      <= 1'b0;
      r_at_target <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_addr      <= w_addr;
      r_data      <= w_data;
      r_write     <= w_write;
      r_busy      <= (w_next != S_IDLE);
      r_at_target <= (r_cur_h == clamp_tgt(i_tgt_h)) && (r_cur_v == clamp_tgt(i_tgt_v));
      r_overrun   <= r_overrun | (r_edge && (r_state != S_IDLE));
    end
  end

  assign o_sf_addr   = r_addr;
  assign o_sf_data   = r_data;
  assign o_sf_write  = r_write;
  assign o_busy      = r_busy;
  assign o_at_target = r_at_target;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_starfield_ramp.sv
// Scoreboard bench for starfield_ramp: two instances (FRAMES=1 and FRAMES=3) share
// stimulus; a frame-level model predicts each register write.
module tb_starfield_ramp;
  localparam int STEP = 32;

  logic        clk = 1'b0, rst_n = 1'b0, vblank = 1'b0, en_req = 1'b0, snap = 1'b0;
  logic [15:0] tgt_h = 16'd0, tgt_v = 16'd0;
  logic [2:0]  a0, a1;
  logic [7:0]  d0, d1;
  logic        w0, w1, b0, b1, t0, t1, ov0, ov1;

  starfield_ramp u0 (
    .clk(clk), .rst_n(rst_n), .i_vblank(vblank), .i_en_req(en_req), .i_tgt_h(tgt_h),
    .i_tgt_v(tgt_v), .i_snap(snap), .o_sf_addr(a0), .o_sf_data(d0), .o_sf_write(w0),
    .o_busy(b0), .o_at_target(t0), .o_overrun(ov0));

  starfield_ramp #(.FRAMES(8'd3)) u1 (
    .clk(clk), .rst_n(rst_n), .i_vblank(vblank), .i_en_req(en_req), .i_tgt_h(tgt_h),
    .i_tgt_v(tgt_v), .i_snap(snap), .o_sf_addr(a1), .o_sf_data(d1), .o_sf_write(w1),
    .o_busy(b1), .o_at_target(t1), .o_overrun(ov1));

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  int fr [2] = '{1, 3};
  int m_h [2], m_v [2], m_cnt [2];
  bit m_snap [2], m_enl [2], m_den [2], m_dh [2], m_dv [2], m_ovr [2];
  longint m_idle [2];
  logic [10:0] q0 [$];
  logic [10:0] q1 [$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampi(input logic [15:0] x);
    int v;
    v = $signed(x);
    return (v == -32768) ? -32767 : v;
  endfunction

  function automatic int step_to(input int c, input int t, input bit s);
    int d;
    d = t - c;
    if (s || (d <= STEP && d >= -STEP)) return t;
    return (d > 0) ? c + STEP : c - STEP;
  endfunction

  task automatic push(input int i, input int a, input int d);
    logic [10:0] e;
    e = {a[2:0], d[7:0]};
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Sign/magnitude register pair for one axis
  task automatic push_axis(input int i, input int c, input int base);
    int m;
    m = (c < 0) ? -c : c;
    push(i, base, ((c >= 0) ? 128 : 0) + (m >> 8));
    push(i, base + 1, m & 255);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_h[i] = 0; m_v[i] = 0; m_cnt[i] = 0; m_snap[i] = 0; m_enl[i] = 0;
      m_den[i] = 1; m_dh[i] = 1; m_dv[i] = 1; m_ovr[i] = 0; m_idle[i] = 0;
    end
    q0.delete(); q1.delete();
  endtask

  // k: clock count at which the rising vblank is first sampled
  task automatic model_edge(input longint k);
    for (int i = 0; i < 2; i++) begin
      bit tick, endirty;
      int n, nh, nv;
      if (k < m_idle[i]) begin m_ovr[i] = 1; continue; end
      tick = (m_cnt[i] == fr[i] - 1);
      m_cnt[i] = tick ? 0 : m_cnt[i] + 1;
      endirty = m_den[i] || (en_req != m_enl[i]);
      if (!tick && !endirty) continue;
      n = 0;
      if (endirty) begin push(i, 0, int'(en_req)); m_enl[i] = en_req; m_den[i] = 0; n++; end
      if (tick) begin
        nh = step_to(m_h[i], clampi(tgt_h), m_snap[i]);
        nv = step_to(m_v[i], clampi(tgt_v), m_snap[i]);
        m_snap[i] = 0;
        if (nh != m_h[i]) m_dh[i] = 1;
        if (nv != m_v[i]) m_dv[i] = 1;
        m_h[i] = nh; m_v[i] = nv;
        if (m_dh[i]) begin push_axis(i, m_h[i], 1); m_dh[i] = 0; n += 2; end
        if (m_dv[i]) begin push_axis(i, m_v[i], 3); m_dv[i] = 0; n += 2; end
      end
      m_idle[i] = k + 2 + n;
    end
  endtask

  // Monitors: every write strobe must match the next predicted write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && w0 === 1'b1) begin
      if (q0.size() == 0) chk("wr0_unexpected", int'({a0, d0}), 'h7ff);
      else begin logic [10:0] e; e = q0.pop_front(); chk("wr0", int'({a0, d0}), int'(e)); end
    end
  end
  always @(negedge clk) begin
    if (rst_n === 1'b1 && w1 === 1'b1) begin
      if (q1.size() == 0) chk("wr1_unexpected", int'({a1, d1}), 'h7ff);
      else begin logic [10:0] e; e = q1.pop_front(); chk("wr1", int'({a1, d1}), int'(e)); end
    end
  end

  task automatic pulse(input int gap);
    @(negedge clk);
    model_edge(cyc + 1);
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic snap_pulse();
    @(negedge clk);
    snap = 1'b1; m_snap[0] = 1; m_snap[1] = 1;
    @(negedge clk);
    snap = 1'b0;
  endtask

  task automatic quiet_checks(input string tag);
    chk({tag, "_q0_drained"}, q0.size(), 0);
    chk({tag, "_q1_drained"}, q1.size(), 0);
    chk({tag, "_busy0"}, int'(b0), 0);
    chk({tag, "_busy1"}, int'(b1), 0);
    chk({tag, "_at_target0"}, int'(t0), int'(m_h[0] == clampi(tgt_h) && m_v[0] == clampi(tgt_v)));
    chk({tag, "_at_target1"}, int'(t1), int'(m_h[1] == clampi(tgt_h) && m_v[1] == clampi(tgt_v)));
    chk({tag, "_overrun0"}, int'(ov0), int'(m_ovr[0]));
    chk({tag, "_overrun1"}, int'(ov1), int'(m_ovr[1]));
  endtask

  initial begin
    int first, busyc;
    bit found;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_addr", int'(a0), 0);
    chk("rst_data", int'(d0), 0);
    chk("rst_write", int'(w0), 0);
    chk("rst_busy", int'(b0), 0);
    chk("rst_overrun", int'(ov0), 0);
    chk("rst_write1", int'(w1), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Full initial write sequence with latency and busy length
    en_req = 1'b1;
    @(negedge clk);
    model_edge(cyc + 1);
    vblank = 1'b1;
    first = -1; busyc = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 1) vblank = 1'b0;
      if (w0 && first < 0) first = j;
      if (b0) busyc++;
    end
    chk("t1_first_write_lat", first, 3);
    chk("t1_busy_cycles", busyc, 6);
    quiet_checks("t1");

    tgt_h = 16'd100;
    repeat (4) pulse(10);
    quiet_checks("t2");
    chk("t2_at_target", int'(t0), 1);

    tgt_h = 16'hFFD8;
    repeat (5) pulse(10);
    quiet_checks("t3");

    tgt_v = 16'h8000;
    snap_pulse();
    pulse(10);
    quiet_checks("t4");
    chk("t4_at_target", int'(t0), 1);

    tgt_h = 16'd64;
    for (int e = 1; e <= 6; e++) begin
      if (e == 1) en_req = ~en_req;
      pulse(10);
    end
    quiet_checks("t5");

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(2) == 0) tgt_h = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom_range(65535));
      if ($urandom_range(2) == 0) tgt_v = 16'($urandom_range(400)) - 16'd200;
      if ($urandom_range(3) == 0) en_req = ~en_req;
      if ($urandom_range(4) == 0) snap_pulse();
      pulse(9 + $urandom_range(3));
      quiet_checks("rnd");
    end

    // Second vblank edge lands while a sequence is in flight
    en_req = ~en_req;
    tgt_h = tgt_h ^ 16'h1000;
    @(negedge clk);
    model_edge(cyc + 1);
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
    repeat (2) @(negedge clk);
    model_edge(cyc + 1);
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
    repeat (12) @(negedge clk);
    quiet_checks("t6a");
    chk("t6_overrun_set", int'(ov0), 1);
    pulse(10);
    chk("t6_overrun_sticky", int'(ov0), 1);

    // Reset in the middle of a write sequence
    en_req = ~en_req;
    tgt_h = tgt_h ^ 16'h0400;
    @(negedge clk);
    model_edge(cyc + 1);
    vblank = 1'b1;
    found = 0;
    for (int j = 1; j <= 10 && !found; j++) begin
      @(negedge clk);
      if (j == 1) vblank = 1'b0;
      if (w0) found = 1;
    end
    chk("t6_write_seen", int'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_write", int'(w0), 0);
    chk("t6_rst_busy", int'(b0), 0);
    chk("t6_rst_overrun", int'(ov0), 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse(10);
    quiet_checks("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
